// File: rtl/tone_player_if.sv
// Control and status bundle for tone_player: note request inputs and
// buzzer/busy/over outputs. The master drives requests; the slave is the player.
interface tone_player_if;
    logic       en;
    logic       start;
    logic [1:0] octave;
    logic [2:0] note;
    logic [2:0] length;
    logic       buzzer;
    logic       busy;
    logic       over;

    modport master (
        output en, start, octave, note, length,
        input  buzzer, busy, over
    );

    modport slave (
        input  en, start, octave, note, length,
        output buzzer, busy, over
    );
endinterface

// File: rtl/tone_player.sv
// Single-note square-wave tone player: IDLE -> PLAY (-> GAP) -> IDLE.
// Optional feature macro: TONE_GAP_EN adds a silent GAP state after each note.
module tone_player #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int UNIT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000
) (
    input  logic          clk,
    input  logic          rst,
    tone_player_if.slave  bus
);

    localparam int DW = $clog2(8 * UNIT_CYCLES + 1);

    if (UNIT_CYCLES < 1 || GAP_CYCLES < 0 || CLK_HZ < 2 * 494) begin : g_bad_params
        $error("tone_player: unsupported CLK_HZ/UNIT_CYCLES/GAP_CYCLES");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY
`ifdef TONE_GAP_EN
        , S_GAP
`endif
    } state_t;

    // Mid-octave half-period per note, then scaled by octave.
    function automatic logic [18:0] hp_of(input logic [2:0] n, input logic [1:0] o);
        logic [19:0] base;
        logic [18:0] hp;
        case (n)
            3'd1:    base = 20'(CLK_HZ / (2 * 262));
            3'd2:    base = 20'(CLK_HZ / (2 * 294));
            3'd3:    base = 20'(CLK_HZ / (2 * 330));
            3'd4:    base = 20'(CLK_HZ / (2 * 349));
            3'd5:    base = 20'(CLK_HZ / (2 * 392));
            3'd6:    base = 20'(CLK_HZ / (2 * 440));
            3'd7:    base = 20'(CLK_HZ / (2 * 494));
            default: base = '0;
        endcase
        case (o)
            2'd0:    hp = 19'(base << 1);
            2'd1:    hp = 19'(base);
            2'd2:    hp = 19'(base >> 1);
            default: hp = 19'(base >> 2);
        endcase
        return hp;
    endfunction

    state_t          r_state, w_state_next;
    logic            r_buzz,  w_buzz_next;
    logic            r_over,  w_over_next;
    logic            r_rest,  w_rest_next;
    logic [18:0]     r_hp,    w_hp_next;
    logic [18:0]     r_pcnt,  w_pcnt_next;
    logic [DW-1:0]   r_dcnt,  w_dcnt_next;
    logic [DW-1:0]   w_dur_load;
    logic            w_pcnt_wrap;

`ifdef TONE_GAP_EN
    localparam int GW = $clog2(GAP_CYCLES + 2);
    logic [GW-1:0]   r_gcnt,  w_gcnt_next;
`endif

    assign w_dur_load  = DW'((32'(bus.length) + 32'd1) * 32'(UNIT_CYCLES) - 32'd1);
    // Compare with a carry bit so an all-ones counter cannot wrap past the limit.
    assign w_pcnt_wrap = ({1'b0, r_pcnt} + 20'd1) >= {1'b0, r_hp};

    always_comb begin
        w_state_next = r_state;
        w_buzz_next  = 1'b0;
        w_over_next  = 1'b0;
        w_rest_next  = r_rest;
        w_hp_next    = r_hp;
        w_pcnt_next  = r_pcnt;
        w_dcnt_next  = r_dcnt;
`ifdef TONE_GAP_EN
        w_gcnt_next  = r_gcnt;
`endif
        if (!bus.en) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_state_next = S_PLAY;
                        w_hp_next    = hp_of(bus.note, bus.octave);
                        w_rest_next  = (bus.note == 3'd0);
                        w_buzz_next  = (bus.note != 3'd0);
                        w_pcnt_next  = '0;
                        w_dcnt_next  = w_dur_load;
                    end
                end
                S_PLAY: begin
                    if (r_dcnt == '0) begin
`ifdef TONE_GAP_EN
                        if (GAP_CYCLES > 0) begin
                            w_state_next = S_GAP;
                            w_gcnt_next  = GW'(GAP_CYCLES - 1);
                        end else begin
                            w_state_next = S_IDLE;
                            w_over_next  = 1'b1;
                        end
`else
                        w_state_next = S_IDLE;
                        w_over_next  = 1'b1;
`endif
                    end else begin
                        w_dcnt_next = r_dcnt - 1'b1;
                        w_buzz_next = r_buzz;
                        if (!r_rest) begin
                            if (w_pcnt_wrap) begin
                                w_buzz_next = ~r_buzz;
                                w_pcnt_next = '0;
                            end else begin
                                w_pcnt_next = r_pcnt + 19'd1;
                            end
                        end
                    end
                end
`ifdef TONE_GAP_EN
                S_GAP: begin
                    if (r_gcnt == '0) begin
                        w_state_next = S_IDLE;
                        w_over_next  = 1'b1;
                    end else begin
                        w_gcnt_next = r_gcnt - 1'b1;
                    end
                end
`endif
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_buzz  <= 1'b0;
            r_over  <= 1'b0;
            r_rest  <= 1'b0;
            r_hp    <= '0;
            r_pcnt  <= '0;
            r_dcnt  <= '0;
`ifdef TONE_GAP_EN
            r_gcnt  <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            r_buzz  <= w_buzz_next;
            r_over  <= w_over_next;
            r_rest  <= w_rest_next;
            r_hp    <= w_hp_next;
            r_pcnt  <= w_pcnt_next;
            r_dcnt  <= w_dcnt_next;
`ifdef TONE_GAP_EN
            r_gcnt  <= w_gcnt_next;
`endif
        end
    end

    assign bus.buzzer = r_buzz;
    assign bus.over   = r_over;
    assign bus.busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_tone_player.sv
// Directed self-checking bench for tone_player at CLK_HZ=8800, UNIT=40, GAP=8.
module tb_tone_player;

    localparam int CLK_HZ = 8800;
    localparam int UNIT   = 40;
    localparam int GAP    = 8;
`ifdef TONE_GAP_EN
    localparam int GAP_EXP = GAP;
`else
    localparam int GAP_EXP = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    tone_player_if bus ();

    tone_player #(
        .CLK_HZ      (CLK_HZ),
        .UNIT_CYCLES (UNIT),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] oct, input logic [2:0] nt, input logic [2:0] len);
        bus.en     = 1'b1;
        bus.octave = oct;
        bus.note   = nt;
        bus.length = len;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
    endtask

    // Starts in PLAY cycle 1 and returns positioned in the over cycle (no tick taken there).
    task automatic check_note(input int hp, input int len, input bit rest, input bit scramble,
                              input string name);
        int  play;
        int  errs;
        logic exp_bz;
        play = (len + 1) * UNIT;
        errs = 0;
        for (int k = 1; k <= play; k++) begin
            exp_bz = rest ? 1'b0 : ((((k - 1) / hp) % 2) == 0);
            vectors++;
            if (bus.buzzer !== exp_bz || bus.busy !== 1'b1 || bus.over !== 1'b0) begin
                miscompares++;
                errs++;
                $display("FAIL %s play cycle %0d: buzzer=%b busy=%b over=%b, required buzzer=%b busy=1 over=0",
                         name, k, bus.buzzer, bus.busy, bus.over, exp_bz);
            end
            if (scramble && (k % 7 == 3)) begin
                bus.start  = 1'b1;
                bus.octave = 2'($urandom_range(0, 3));
                bus.note   = 3'($urandom_range(0, 7));
                bus.length = 3'($urandom_range(0, 7));
            end else begin
                bus.start = 1'b0;
            end
            tick();
        end
        bus.start = 1'b0;
        for (int g = 1; g <= GAP_EXP; g++) begin
            vectors++;
            if (bus.buzzer !== 1'b0 || bus.busy !== 1'b1 || bus.over !== 1'b0) begin
                miscompares++;
                errs++;
                $display("FAIL %s gap cycle %0d: buzzer=%b busy=%b over=%b, required buzzer=0 busy=1 over=0",
                         name, g, bus.buzzer, bus.busy, bus.over);
            end
            tick();
        end
        vectors++;
        if (bus.over !== 1'b1 || bus.busy !== 1'b0 || bus.buzzer !== 1'b0) begin
            miscompares++;
            errs++;
            $display("FAIL %s over cycle: over=%b busy=%b buzzer=%b, required over=1 busy=0 buzzer=0",
                     name, bus.over, bus.busy, bus.buzzer);
        end
        $display("note %s: hp=%0d len=%0d rest=%0d play=%0d gap=%0d errors=%0d",
                 name, hp, len, rest, play, GAP_EXP, errs);
    endtask

    task automatic check_idle(input int cycles, input string name);
        for (int c = 0; c < cycles; c++) begin
            vectors++;
            if (bus.over !== 1'b0 || bus.busy !== 1'b0 || bus.buzzer !== 1'b0) begin
                miscompares++;
                $display("FAIL %s idle cycle %0d: over=%b busy=%b buzzer=%b, required all 0",
                         name, c, bus.over, bus.busy, bus.buzzer);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        bus.en = 1'b1; bus.start = 1'b1; bus.octave = 2'd1; bus.note = 3'd6; bus.length = 3'd0;
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (bus.busy !== 1'b0 || bus.buzzer !== 1'b0 || bus.over !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: busy=%b buzzer=%b over=%b, required all 0", bus.busy, bus.buzzer, bus.over);
        end
        bus.start = 1'b0;
        rst = 1'b0;
        tick();
        check_idle(3, "post_reset");
        $display("reset: checked");
    endtask

    task automatic test_note_a();
        launch(2'd1, 3'd6, 3'd0);
        check_note(10, 0, 1'b0, 1'b0, "A_oct1");
        tick();
        check_idle(2, "A_oct1_after");
    endtask

    task automatic test_octave_sweep();
        int hp_tab [4] = '{20, 10, 5, 2};
        for (int o = 0; o < 4; o++) begin
            launch(2'(o), 3'd6, 3'd0);
            check_note(hp_tab[o], 0, 1'b0, 1'b0, $sformatf("A_oct%0d", o));
            tick();
            check_idle(1, "sweep_after");
        end
    endtask

    task automatic test_rest();
        launch(2'd1, 3'd0, 3'd2);
        check_note(1, 2, 1'b1, 1'b0, "rest_len2");
        tick();
        check_idle(2, "rest_after");
    endtask

    task automatic test_back_to_back();
        launch(2'd1, 3'd6, 3'd0);
        check_note(10, 0, 1'b0, 1'b1, "A_scrambled");
        // Second note (C mid, 8800/524 = 16) starts in the over cycle.
        launch(2'd1, 3'd1, 3'd1);
        check_note(16, 1, 1'b0, 1'b0, "C_back_to_back");
        launch(2'd2, 3'd2, 3'd0);
        check_note(7, 0, 1'b0, 1'b0, "D_oct2_back_to_back");
        tick();
        check_idle(2, "b2b_after");
    endtask

    task automatic test_abort(input bit use_rst, input string name);
        launch(2'd2, 3'd6, 3'd2);
        for (int k = 1; k < 15; k++) tick();
        vectors++;
        if (bus.busy !== 1'b1 || bus.buzzer !== 1'b1) begin
            miscompares++;
            $display("FAIL %s cycle15: busy=%b buzzer=%b, required busy=1 buzzer=1", name, bus.busy, bus.buzzer);
        end
        if (use_rst) rst = 1'b1; else bus.en = 1'b0;
        tick();
        rst = 1'b0;
        bus.en = 1'b1;
        check_idle(UNIT * 3 + GAP + 4, name);
        $display("abort %s: checked", name);
    endtask

    task automatic test_en_low_start();
        bus.en = 1'b0; bus.start = 1'b1; bus.octave = 2'd1; bus.note = 3'd6; bus.length = 3'd0;
        tick();
        check_idle(3, "en_low_start");
        bus.start = 1'b0;
        bus.en = 1'b1;
        tick();
        check_idle(2, "en_low_after");
        $display("en_low start: checked");
    endtask

    initial begin
        bus.en = 1'b0; bus.start = 1'b0; bus.octave = '0; bus.note = '0; bus.length = '0;
        test_reset();
        test_note_a();
        test_octave_sweep();
        test_rest();
        test_back_to_back();
        test_abort(1'b0, "en_drop");
        test_abort(1'b1, "rst_mid");
        test_en_low_start();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
